adder32_seq_ctrl: RTL
=====================

Name: adder32_seq_ctrl

Overview:
- Multi-cycle WIDTH-bit adder controller that time-shares one adder8 slice (8-bit ripple: two adder4) across NSLICE = WIDTH/8 cycles.
- Latches operands on a valid/ready input handshake and feeds one byte per cycle through the slice, least-significant byte first.
- Carries the slice's c8 in a register between cycles.
- Presents the sum, carry-out and signed overflow behind a valid/ready output handshake.
- Serves as the area-reduced alternative to a fully unrolled adder32 in the adder datapath.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of 8 and at least 8; NSLICE = WIDTH/8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A, B, c0 are valid.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- c0  input  1  carry-in to bit 0.
- out_valid  output  1  S, cout, ovf are valid.
- out_ready  input  1  downstream consumes the result.
- S  output  WIDTH  sum A+B+c0 (mod 2^WIDTH).
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in CALC or HOLD.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, slice index idx=0, carry register=0, S=0, cout=0, ovf=0.
  - out_valid=0, busy=0, in_ready=1 (registered or derived from state IDLE).
  - A/B operand registers cleared to 0.
- Reset asserted mid-CALC or mid-HOLD abandons the operation. No result is presented; out_valid stays 0 after release.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at edge: latch A, B; carry<=c0; idx<=0; S<=0; go CALC.
  - CALC: the single adder8 instance sees A_reg[8*idx+7:8*idx], B_reg slice and carry. At each edge:
    - S[8*idx+7:8*idx] <= slice sum; carry <= slice c8; idx <= idx+1.
    - When idx==NSLICE-1 at the edge: cout <= c8, ovf <= computed, go HOLD.
  - HOLD: out_valid=1. S/cout/ovf held stable until out_valid&out_ready at an edge, then go IDLE.
- ovf = (A_reg[WIDTH-1]==B_reg[WIDTH-1]) & (S[WIDTH-1]!=A_reg[WIDTH-1]), using the final MSB slice sum. It is registered with cout.
- Latency: accept edge T → out_valid high after edge T+NSLICE (4 cycles for WIDTH=32).
- Throughput: with out_ready held high, handshake at edge T+NSLICE+1, IDLE, next accept at T+NSLICE+2. Minimum spacing NSLICE+2 edges.
- in_ready=0 in CALC and HOLD. No input is accepted while a result is pending, including on the same edge as the output handshake.
- in_valid is ignored outside IDLE. A/B/c0 may change freely after acceptance without affecting the result.
- out_valid never drops without out_ready. S/cout/ovf do not change while out_valid=1.
- S/cout/ovf keep the last result in IDLE; they are partially overwritten during the next CALC. Consumers sample only under out_valid.
- idx width = max(1, clog2(NSLICE)). No wrap beyond NSLICE-1.
- WIDTH=8 edge case: CALC lasts one cycle.

Test Plan:
- Carry propagation: A=0xFFFFFFFF, B=0x00000001, c0=0 → S=0x00000000, cout=1, ovf=0; out_valid exactly 4 cycles after the accept edge.
- Overflow and cross-slice carry:
  - A=0x7FFFFFFF, B=0x00000001 → S=0x80000000, cout=0, ovf=1.
  - A=0x000000FF, B=0, c0=1 → S=0x00000100, cout=0, ovf=0.
- Backpressure: A=0x12345678, B=0x11111111, out_ready low 5 cycles in HOLD → S=0x23456789 stable, out_valid=1, in_ready=0 throughout. Raise out_ready → IDLE next cycle.
- Back-to-back with in_valid held high and out_ready=1: accept (1,2) then (0x80000000, 0x80000000) → S=3 then S=0 with cout=1, ovf=1. Accept edges spaced exactly 6 cycles apart; operand changes during CALC ignored.
- Reset mid-CALC: assert rst at idx=2 → immediately out_valid=0, busy=0, S=0, in_ready=1. Next operation (5+7) yields S=12 with normal latency.

Source files
------------

// File: rtl/adder32_seq_ctrl.sv
// Sequential WIDTH-bit adder: one 8-bit ripple slice (two 4-bit halves) is reused
// for WIDTH/8 cycles, least-significant byte first, behind valid/ready handshakes.
module adder32_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 8;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [7:0]       sum_byte;
    logic             c4;
    logic             c8;

    function automatic logic [4:0] add4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic       c;
        logic [3:0] s;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    // The one shared slice: byte idx of each operand plus the carry held from the previous byte.
    assign a_byte = a_reg[{idx, 3'b000} +: 8];
    assign b_byte = b_reg[{idx, 3'b000} +: 8];
    assign {c4, sum_byte[3:0]} = add4(a_byte[3:0], b_byte[3:0], carry);
    assign {c8, sum_byte[7:4]} = add4(a_byte[7:4], b_byte[7:4], c4);

    // NOTE: every register here, operands included, is cleared by rst so an aborted
    // operation leaves nothing behind; state updates use <= so all of them see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            S         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        carry    <= c0;
                        idx      <= '0;
                        S        <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    S[{idx, 3'b000} +: 8] <= sum_byte;
                    carry <= c8;
                    if (idx == LAST) begin
                        cout      <= c8;
                        ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (sum_byte[7] != a_reg[WIDTH-1]);
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                HOLD: begin
                    // Result stays frozen until consumed; no new accept on this edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
